// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle ALU (Booth MUL, restoring DIV) feeding ZHi/ZLo.
// Ports: Clock, Clear (async low), Start/Op/A/B in; Busy, Done, ZHi, ZLo, Carry, DivZero out.
module seq_alu_core #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ZHi,
    output logic [WIDTH-1:0] ZLo,
    output logic             Carry,
    output logic             DivZero
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_NEG  = 4'd10;
    localparam logic [3:0] OP_NOT  = 4'd11;
    localparam logic [3:0] OP_SHRA = 4'd12;

    typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DIV_FIX} state_t;

    state_t state, state_nx;

    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     hi;      // Booth accumulator / divider remainder
    logic [WIDTH-1:0]   lo;      // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   opd;     // multiplicand / divisor magnitude
    logic               q1;
    logic               neg_q;
    logic               neg_r;

    logic accept, b_zero, last;

    assign accept = Start && (state == IDLE);
    assign b_zero = (B == '0);
    assign last   = (cnt == SHW'(WIDTH - 1));
    assign Busy   = (state != IDLE);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && Op == OP_MUL)
                    state_nx = MUL_IT;
                else if (accept && Op == OP_DIV && !b_zero)
                    state_nx = DIV_IT;
            end
            MUL_IT:  if (last) state_nx = IDLE;
            DIV_IT:  if (last) state_nx = DIV_FIX;
            DIV_FIX: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle datapath
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_s, sub_s;
    logic [2*WIDTH-1:0] dbl_r, dbl_l;
    logic [WIDTH-1:0]   r_lo;
    logic               r_c, r_cw;

    assign sh    = B[SHW-1:0];
    assign add_s = {1'b0, A} + {1'b0, B};
    assign sub_s = {1'b0, A} - {1'b0, B};
    // Rotates come from shifting a doubled copy of A.
    assign dbl_r = {A, A} >> sh;
    assign dbl_l = {A, A} << sh;

    always_comb begin
        r_lo = '0;
        r_c  = Carry;
        r_cw = 1'b0;
        case (Op)
            OP_AND:  r_lo = A & B;
            OP_OR:   r_lo = A | B;
            OP_ADD: begin
                r_lo = add_s[WIDTH-1:0];
                r_c  = add_s[WIDTH];
                r_cw = 1'b1;
            end
            OP_SUB: begin
                r_lo = sub_s[WIDTH-1:0];
                r_c  = ~sub_s[WIDTH];
                r_cw = 1'b1;
            end
            OP_SHR:  r_lo = A >> sh;
            OP_SHL:  r_lo = A << sh;
            OP_ROR:  r_lo = dbl_r[WIDTH-1:0];
            OP_ROL:  r_lo = dbl_l[2*WIDTH-1:WIDTH];
            OP_NEG:  r_lo = -B;
            OP_NOT:  r_lo = ~B;
            OP_SHRA: r_lo = $signed(A) >>> sh;
            default: r_lo = '0;
        endcase
    end

    // Booth step: one guard bit keeps -2^(W-1) multiplicands exact.
    logic [WIDTH:0] m_ext, acc_nx;

    assign m_ext = {opd[WIDTH-1], opd};

    always_comb begin
        unique case ({lo[0], q1})
            2'b01:   acc_nx = hi + m_ext;
            2'b10:   acc_nx = hi - m_ext;
            default: acc_nx = hi;
        endcase
    end

    // Restoring divide step on magnitudes
    logic [WIDTH:0]   trial, diff;
    logic             fit;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign trial = {hi[WIDTH-1:0], lo[WIDTH-1]};
    assign diff  = trial - {1'b0, opd};
    assign fit   = ~diff[WIDTH];
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            opd     <= '0;
            q1      <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            Done    <= 1'b0;
            ZHi     <= '0;
            ZLo     <= '0;
            Carry   <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (Op == OP_MUL) begin
                            hi  <= '0;
                            lo  <= B;
                            opd <= A;
                            q1  <= 1'b0;
                        end else if (Op == OP_DIV) begin
                            if (b_zero) begin
                                ZHi     <= A;
                                ZLo     <= '1;
                                DivZero <= 1'b1;
                                Done    <= 1'b1;
                            end else begin
                                hi    <= '0;
                                lo    <= a_mag;
                                opd   <= b_mag;
                                neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                                neg_r <= A[WIDTH-1];
                            end
                        end else begin
                            ZLo   <= r_lo;
                            ZHi   <= {{(WIDTH-1){1'b0}}, r_cw & r_c};
                            Carry <= r_c;
                            Done  <= 1'b1;
                        end
                    end
                end
                MUL_IT: begin
                    hi  <= {acc_nx[WIDTH], acc_nx[WIDTH:1]};
                    lo  <= {acc_nx[0], lo[WIDTH-1:1]};
                    q1  <= lo[0];
                    cnt <= cnt + SHW'(1);
                    if (last) begin
                        ZHi  <= acc_nx[WIDTH:1];
                        ZLo  <= {acc_nx[0], lo[WIDTH-1:1]};
                        Done <= 1'b1;
                    end
                end
                DIV_IT: begin
                    hi  <= fit ? {1'b0, diff[WIDTH-1:0]}
                               : {1'b0, trial[WIDTH-1:0]};
                    lo  <= {lo[WIDTH-2:0], fit};
                    cnt <= cnt + SHW'(1);
                end
                DIV_FIX: begin
                    ZLo     <= neg_q ? -lo : lo;
                    ZHi     <= neg_r ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
                    DivZero <= 1'b0;
                    Done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
- Parametrised, multi-cycle replacement for the datapath's combinational ALU feeding the ZHi/ZLo register pair.
- Takes operand A from the Y register and operand B from the bus. Runs 13 operations under a Start/Done handshake.
- MUL uses an iterative radix-2 Booth multiplier; DIV uses an iterative signed restoring divider.
- Results are registered internally and held until the next completed operation, so the control unit can read ZHi/ZLo on any later cycle.

Parameters:
- WIDTH, 32, operand width; the result pair is 2*WIDTH bits.
- SHW, 5, shift-amount bits taken from B[SHW-1:0]; must equal clog2(WIDTH).

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only while Busy=0.
- Op  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 SHRA; 13-15 reserved.
- A  in  WIDTH  operand A (Y register).
- B  in  WIDTH  operand B (bus).
- Busy  out  1  multi-cycle operation in progress.
- Done  out  1  one-cycle pulse; ZHi/ZLo/flags updated this cycle.
- ZHi  out  WIDTH  high result word.
- ZLo  out  WIDTH  low result word.
- Carry  out  1  carry out of ADD, or NOT borrow for SUB.
- DivZero  out  1  last DIV had B=0.

Behaviour:
Reset (Clear=0, asynchronous):
- State goes to IDLE.
- Busy, Done, ZHi, ZLo, Carry and DivZero all go to 0.
- Reset mid-operation aborts the operation with no Done pulse.

Operand capture:
- A, B and Op are latched on the edge where Start=1 and Busy=0.
- Later changes to A, B or Op do not affect the operation in flight.
- Start while Busy=1 is ignored; it is neither queued nor an error.

States:
- IDLE: waits for Start.
- MUL_IT: runs WIDTH iterations.
- DIV_IT: runs WIDTH iterations.
- DIV_FIX: one cycle of sign correction.
- Busy=1 exactly while the state is MUL_IT, DIV_IT or DIV_FIX.

Single-cycle ops (all except 4 and 5):
- Start accepted at edge k; results registered and Done=1 during the cycle after edge k.
- State stays IDLE, so Busy remains 0.
- ZHi=0 except for ADD/SUB, where ZHi = {WIDTH-1 zeros, carry}.

Operation definitions:
- SHR is logical; SHRA is arithmetic.
- SHL, ROR and ROL shift by B[SHW-1:0]; shift amount 0 returns A unchanged.
- NEG = two's complement of B; NOT = ~B.
- Carry updates only on ADD/SUB and holds its value otherwise.

MUL:
- Signed two's-complement, {ZHi,ZLo} = A*B.
- Completes after WIDTH cycles in MUL_IT; Done asserts on the cycle of return to IDLE, WIDTH+1 cycles after the Start edge.
- An internal iteration counter runs from 0 to WIDTH-1.

DIV:
- Signed. ZLo = quotient truncated toward zero; ZHi = remainder with the sign of the dividend.
- Division runs on magnitudes in DIV_IT (WIDTH cycles); signs are applied in DIV_FIX.
- Done asserts WIDTH+2 cycles after the Start edge.
- Overflow case: -2^(WIDTH-1) / -1 gives ZLo=-2^(WIDTH-1), ZHi=0 (wrap, no flag).

DIV with B=0:
- Skips iteration; Done asserts the cycle after Start.
- ZLo = all ones, ZHi = A, DivZero=1.
- DivZero clears on the next completed DIV with B≠0 and is unaffected by other ops.

Reserved opcodes:
- Complete in 1 cycle with ZHi=ZLo=0 and flags unchanged.

Handshake and result hold:
- Back-to-back issue: Start may be high in the same cycle Done is high (Busy=0 then), and that request is accepted.
- ZHi/ZLo hold their value between Done pulses; intermediate iteration values are never visible on ZHi/ZLo.

Test Plan:
- Reset mid-MUL: start MUL, pull Clear low at iteration 10 -> Busy=0, ZHi=ZLo=0, no Done pulse.
- ADD then SUB back-to-back, WIDTH=32:
  - A=0xFFFFFFFF, B=1 ADD -> ZLo=0, Carry=1, Done at k+1.
  - Start held high in the Done cycle with SUB A=5, B=7 -> ZLo=0xFFFFFFFE, Carry=0.
- MUL: A=-7, B=6 -> ZHi=0xFFFFFFFF, ZLo=0xFFFFFFD6, Done exactly 33 cycles after the Start edge. Start pulses during Busy are ignored.
- DIV: A=-17, B=5 -> ZLo=-3, ZHi=-2, Done at 34 cycles.
- DIV boundaries:
  - 0x80000000 / -1 -> ZLo=0x80000000, ZHi=0.
  - B=0 with A=9 -> ZLo=0xFFFFFFFF, ZHi=9, DivZero=1, Done at 1 cycle.
- Shifts/rotates, A=0x80000001:
  - SHR 1 -> 0x40000000.
  - SHRA 1 -> 0xC0000000.
  - ROR 1 -> 0xC0000000.
  - ROL 4 -> 0x00000018.
  - SHL with B=32 (amount 0) -> A unchanged.
  - Repeat the MUL case with WIDTH=16, SHW=4 -> Done at 17 cycles.
